// File: rtl/hamming_pkg.sv
// Shared types, constants and the SECDED decode function for the Hamming engine.
// Pure combinational helpers; no state, no flow control.
package hamming_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      FIN   = 3'd5
   } state_t;

   localparam int NUM_WORDS = 15;
   localparam int IN_BASE   = 30;
   localparam int OUT_BASE  = 0;

   // Result packs {dbl, sgl, 3'b0, d11..d1}; a double error returns the raw data bits.
   function automatic logic [15:0] decode(input logic [15:0] cw);
      logic [3:0]  syn;
      logic        par;
      logic [15:0] fixed;
      logic [10:0] dat;
      syn = 4'd0;
      for (int k = 1; k < 16; k++) begin
         if (cw[k]) syn = syn ^ 4'(k);
      end
      par   = ^cw;
      fixed = par ? (cw ^ (16'd1 << syn)) : cw;
      dat   = {fixed[15:9], fixed[7:5], fixed[3]};
      if (par)
         decode = {2'b01, 3'b000, dat};
      else if (syn != 4'd0)
         decode = {2'b10, 3'b000, dat};
      else
         decode = {2'b00, 3'b000, dat};
   endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, write on rising clock edge.
// Single port, one access per cycle; contents are never reset.
module data_mem (
   input  logic       clock,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] core [0:255];

   always_ff @(posedge clock) begin
      if (we) core[addr] <= wdata;
   end

   assign rdata = core[addr];

endmodule

// File: rtl/top_level.sv
// SECDED decoder engine: reads 15 codewords, writes 15 flagged results, then raises done.
// 4 cycles per word, done 61 edges after start; start ignored while a run is in flight.
module top_level
   import hamming_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   output logic done
);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [7:0]  lo_byte, hi_byte;
   logic [7:0]  addr, wdata, rdata;
   logic        we;
   logic [15:0] result;

   assign result = decode({hi_byte, lo_byte});

   data_mem dm1 (
      .clock (clock),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         lo_byte <= 8'd0;
         hi_byte <= 8'd0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == FIN) && !start;
         case (state)
            IDLE, FIN: if (start) cnt <= 4'd0;
            RD_LO:     lo_byte <= rdata;
            RD_HI:     hi_byte <= rdata;
            WR_HI:     if (cnt != 4'(NUM_WORDS - 1)) cnt <= cnt + 4'd1;
            default:   ;
         endcase
      end
   end

   // Writes are gated by reset so a mid-run reset leaves the pending byte untouched.
   always_comb begin
      state_nxt = state;
      addr      = 8'd0;
      wdata     = 8'd0;
      we        = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RD_LO;
         RD_LO: begin
            addr      = 8'(IN_BASE) + {3'b000, cnt, 1'b0};
            state_nxt = RD_HI;
         end
         RD_HI: begin
            addr      = 8'(IN_BASE) + {3'b000, cnt, 1'b1};
            state_nxt = WR_LO;
         end
         WR_LO: begin
            addr      = 8'(OUT_BASE) + {3'b000, cnt, 1'b0};
            wdata     = result[7:0];
            we        = reset_n;
            state_nxt = WR_HI;
         end
         WR_HI: begin
            addr      = 8'(OUT_BASE) + {3'b000, cnt, 1'b1};
            wdata     = result[15:8];
            we        = reset_n;
            state_nxt = (cnt == 4'(NUM_WORDS - 1)) ? FIN : RD_LO;
         end
         FIN:   if (start) state_nxt = RD_LO;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for the SECDED engine: preloads memory, times done, checks results.
module tb_top_level;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   logic d0;

   logic [15:0] in_w  [15];
   logic [15:0] exp_w [15];

   top_level dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .done    (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_inputs();
      for (int i = 0; i < 15; i++) begin
         dut.dm1.core[30 + 2*i] <= in_w[i][7:0];
         dut.dm1.core[31 + 2*i] <= in_w[i][15:8];
      end
   endtask

   task automatic fill_outputs(input logic [7:0] v);
      for (int a = 0; a < 30; a++) dut.dm1.core[a] <= v;
   endtask

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 15; i++)
         check($sformatf("%s_w%0d", tag, i),
               {dut.dm1.core[2*i + 1], dut.dm1.core[2*i]}, exp_w[i]);
   endtask

   task automatic check_inputs(input string tag);
      for (int i = 0; i < 15; i++)
         check($sformatf("%s_in%0d", tag, i),
               {dut.dm1.core[31 + 2*i], dut.dm1.core[30 + 2*i]}, in_w[i]);
   endtask

   // Pulse start for one edge; report done just after that edge and the edge count to done.
   task automatic run_start(output int cycles, output logic done_after_start);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      done_after_start = done;
      start  = 1'b0;
      cycles = 0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clock);
         #1;
         if (done) begin
            cycles = n;
            break;
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check("done_reset", {15'd0, done}, 16'h0000);

      // All-zero codewords
      for (int i = 0; i < 15; i++) begin
         in_w[i]  = 16'h0000;
         exp_w[i] = 16'h0000;
      end
      load_inputs();
      fill_outputs(8'hAA);
      dut.dm1.core[60] <= 8'h5C;
      repeat (4) @(posedge clock);
      #1;
      check("done_idle", {15'd0, done}, 16'h0000);
      run_start(cyc, d0);
      check("lat_zero", 16'(cyc), 16'd61);
      check_outputs("zero");
      repeat (5) @(posedge clock);
      #1;
      check("done_held", {15'd0, done}, 16'h0001);

      // Directed mix: single, double and clean words
      in_w  = '{16'h0008, 16'h0001, 16'h7FFF, 16'h0006, 16'h000F,
                16'h8117, 16'h0233, 16'h0E11, 16'h1A31, 16'h001F,
                16'hFFFF, 16'hFFD7, 16'h0032, 16'h1E11, 16'h4080};
      exp_w = '{16'h4000, 16'h4000, 16'h47FF, 16'h8000, 16'h0001,
                16'h0400, 16'h4002, 16'h40F0, 16'h80D2, 16'h4001,
                16'h07FF, 16'h87FC, 16'h4002, 16'h00F0, 16'h8208};
      @(negedge clock);
      load_inputs();
      fill_outputs(8'hAA);
      run_start(cyc, d0);
      check("done_fin_restart", {15'd0, d0}, 16'h0000);
      check("lat_mix", 16'(cyc), 16'd61);
      check_outputs("mix");
      check_inputs("mix");
      check("sentinel60", {8'h00, dut.dm1.core[60]}, 16'h005C);

      // Reset sampled on the WR_LO edge of word 4: words 0..3 written, word 4 not
      @(negedge clock);
      fill_outputs(8'hAA);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (18) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check("done_after_rst", {15'd0, done}, 16'h0000);
      check("rst_word3", {dut.dm1.core[7], dut.dm1.core[6]}, exp_w[3]);
      check("rst_word4", {dut.dm1.core[9], dut.dm1.core[8]}, 16'hAAAA);
      check("rst_word14", {dut.dm1.core[29], dut.dm1.core[28]}, 16'hAAAA);
      repeat (3) @(posedge clock);
      #1;
      check("done_idle_rst", {15'd0, done}, 16'h0000);
      run_start(cyc, d0);
      check("lat_after_rst", 16'(cyc), 16'd61);
      check_outputs("rst");

      // Second start from FIN repeats the whole run
      @(negedge clock);
      fill_outputs(8'hAA);
      run_start(cyc, d0);
      check("done_drop", {15'd0, d0}, 16'h0000);
      check("lat_rerun", 16'(cyc), 16'd61);
      check_outputs("rerun");
      check_inputs("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
